kbd_rx_fifo: RTL

KBD_RX_FIFO -- requirements
Module: kbd_rx_fifo

---
 rtl/kbd_rx_fifo.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/kbd_rx_fifo.sv
// PS/2 keyboard receiver: sync + glitch filter, frame FSM and FWFT byte FIFO.
// Optional mid-frame watchdog enabled by defining KBD_RX_TIMEOUT_EN.
module kbd_rx_fifo #(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 2000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          kbd_clk,
   input  logic                          kbd_data,
   input  logic                          rd,
   output logic                          rda,
   output logic [7:0]                    data,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = $clog2(FILTER_LEN + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sh;
   logic [SYNC_STAGES-1:0] dat_sh;
   logic                   clk_sync;
   logic                   data_sync;
   logic                   filt;
   logic [FW-1:0]          fcnt;
   logic                   strobe;

   state_t                 state;
   logic [7:0]             shreg;
   logic [2:0]             bitcnt;
   logic                   par;
   logic                   par_ok;
   logic                   good_frame;

   logic [7:0]             mem [FIFO_DEPTH];
   logic [AW-1:0]          wp;
   logic [AW-1:0]          rp;
   logic [CW-1:0]          occ;
   logic                   full;
   logic                   pop;
   logic                   push_ok;

`ifdef KBD_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0]          tcnt;
`endif

   assign clk_sync  = clk_sh[SYNC_STAGES-1];
   assign data_sync = dat_sh[SYNC_STAGES-1];

   // Bring both PS/2 lines into the clk domain; idle level is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sh <= '1;
         dat_sh <= '1;
      end else begin
         clk_sh <= {clk_sh[SYNC_STAGES-2:0], kbd_clk};
         dat_sh <= {dat_sh[SYNC_STAGES-2:0], kbd_data};
      end
   end

   // Accept a new kbd_clk level only after it is stable; strobe on fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt   <= 1'b1;
         fcnt   <= '0;
         strobe <= 1'b0;
      end else begin
         strobe <= 1'b0;
         if (clk_sync != filt) begin
            if (fcnt == FW'(FILTER_LEN - 1)) begin
               filt   <= clk_sync;
               fcnt   <= '0;
               strobe <= filt & ~clk_sync;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end else begin
            fcnt <= '0;
         end
      end
   end

   assign par_ok     = ^{shreg, par};
   assign good_frame = strobe && (state == STOP) && par_ok && data_sync;
   assign full       = (occ == CW'(FIFO_DEPTH));
   assign pop        = rd && rda;
   assign push_ok    = good_frame && (!full || pop);

   // Frame FSM with registered error and overflow pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bitcnt     <= '0;
         par        <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
`ifdef KBD_RX_TIMEOUT_EN
         tcnt       <= '0;
`endif
      end else begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= good_frame && !push_ok;
         if (strobe) begin
            unique case (state)
               IDLE: begin
                  if (!data_sync) begin
                     state  <= DATA;
                     bitcnt <= '0;
                  end
               end
               DATA: begin
                  shreg  <= {data_sync, shreg[7:1]};
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= data_sync;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (!par_ok)
                     parity_err <= 1'b1;
                  else if (!data_sync)
                     frame_err <= 1'b1;
               end
            endcase
         end
`ifdef KBD_RX_TIMEOUT_EN
         // Watchdog: abandon a frame whose clock stopped mid-way.
         if (state == IDLE || strobe) begin
            tcnt <= '0;
         end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            tcnt      <= '0;
            state     <= IDLE;
            frame_err <= 1'b1;
         end else begin
            tcnt <= tcnt + 1'b1;
         end
`endif
      end
   end

   // FIFO storage; contents need no reset since occupancy gates the output.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wp] <= shreg;
   end

   // FIFO pointers and occupancy; pointers wrap on power-of-2 depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         occ <= '0;
      end else begin
         if (push_ok) wp <= wp + 1'b1;
         if (pop)     rp <= rp + 1'b1;
         if (push_ok && !pop)
            occ <= occ + 1'b1;
         else if (!push_ok && pop)
            occ <= occ - 1'b1;
      end
   end

   assign rda   = (occ != '0);
   assign data  = rda ? mem[rp] : 8'h00;
   assign count = occ;

endmodule
